enet_tx_frame_arbiter: RTL and testbench

//  Shares the single 8-bit AXI-stream TX port of the v7 Ethernet controller between N_REQ byte-stream requesters.

---
 rtl/enet_tx_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/enet_tx_frame_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_enet_tx_frame_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enet_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// enet_tx_arb_pkg
//   Shared definitions for the Ethernet TX frame arbiter:
//     - arb_state_e     : FSM state encoding (IDLE, XFER, GAP)
//     - byte_cnt_width  : width of the per-frame byte counter for a given
//                         MAX_FRAME (must be able to hold MAX_FRAME itself)
//     - gap_cnt_width   : width of the inter-frame gap down-counter
//     - idx_width       : width of a requester index (round-robin pointer)
// -----------------------------------------------------------------------------
package enet_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting to arbitrate (or to regrant a split owner)
        ST_XFER = 2'd1,   // owner bytes pass straight through to the controller
        ST_GAP  = 2'd2    // forced idle after every emitted tlast
    } arb_state_e;

    function automatic int byte_cnt_width(input int max_frame);
        return (max_frame < 1) ? 1 : $clog2(max_frame + 1);
    endfunction

    // A zero-cycle gap still gets a 1-bit counter so the declaration stays legal.
    function automatic int gap_cnt_width(input int gap_cycles);
        return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Starting with the requester just
//   after ptr (wrapping), the first asserted req bit wins.
//   Ports:
//     req     in   N    request vector
//     ptr     in   PW   index of the previous winner
//     en      in   1    0 forces gnt to zero and leaves the pointer alone
//     gnt     out  N    one-hot winner, 0 when nothing requested or en=0
//     ptr_new out  PW   index of the winner (equals ptr when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
    import enet_tx_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = idx_width(N)
)(
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr_new
);

    logic found;
    int   idx;

    // NOTE: every output and temporary gets a default before any branch, so no
    // path through this block can leave a value held (which would infer a latch).
    always_comb begin
        gnt     = '0;
        ptr_new = ptr;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            // Scan ptr+1 .. ptr+N so the previous winner is checked last.
            for (int i = 1; i <= N; i++) begin
                idx = (int'(ptr) + i) % N;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    gnt[idx]   = 1'b1;
                    ptr_new    = PW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/enet_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// enet_tx_frame_arbiter
//   Shares the single 8-bit AXI-stream TX port of the Ethernet controller
//   between N_REQ byte-stream requesters. Frames are arbitrated round-robin at
//   frame granularity, split at MAX_FRAME bytes, and separated by GAP_CYCLES
//   idle cycles. Everything runs on the controller's TX clock.
//
//   Parameters:
//     N_REQ       number of requesters (>= 2)
//     MAX_FRAME   max payload bytes per emitted frame
//     GAP_CYCLES  idle cycles forced after each emitted tlast (0 = none)
//
//   Ports:
//     i_axi_tx_clk     in   1        TX clock, rising edge
//     i_axi_tx_rst_n   in   1        synchronous active-low reset
//     i_enable         in   1        0 blocks new grants; current frame completes
//     i_req_tdata      in   8*N_REQ  requester k at [8k+7:8k]
//     i_req_tvalid     in   N_REQ
//     i_req_tlast      in   N_REQ
//     o_req_tready     out  N_REQ    only the owner sees the controller tready
//     o_axi_tx_tdata   out  8
//     o_axi_tx_tvalid  out  1
//     o_axi_tx_tlast   out  1        source tlast or MAX_FRAME limit
//     i_axi_tx_tready  in   1
//     o_grant          out  N_REQ    one-hot owner, 0 when none
//     o_frame_cnt      out  32       emitted frames (wraps)
//     o_split_cnt      out  16       frames closed by the size limit (wraps)
// -----------------------------------------------------------------------------
module enet_tx_frame_arbiter
    import enet_tx_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int MAX_FRAME  = 1024,
    parameter int GAP_CYCLES = 12
)(
    input  logic                 i_axi_tx_clk,
    input  logic                 i_axi_tx_rst_n,
    input  logic                 i_enable,
    input  logic [8*N_REQ-1:0]   i_req_tdata,
    input  logic [N_REQ-1:0]     i_req_tvalid,
    input  logic [N_REQ-1:0]     i_req_tlast,
    output logic [N_REQ-1:0]     o_req_tready,
    output logic [7:0]           o_axi_tx_tdata,
    output logic                 o_axi_tx_tvalid,
    output logic                 o_axi_tx_tlast,
    input  logic                 i_axi_tx_tready,
    output logic [N_REQ-1:0]     o_grant,
    output logic [31:0]          o_frame_cnt,
    output logic [15:0]          o_split_cnt
);

    localparam int BCW = byte_cnt_width(MAX_FRAME);
    localparam int GCW = gap_cnt_width(GAP_CYCLES);
    localparam int PW  = idx_width(N_REQ);

    // Byte index of the last beat a frame may carry before it is forced closed.
    localparam logic [BCW-1:0] LAST_BYTE_IDX = BCW'(MAX_FRAME - 1);
    localparam logic [GCW-1:0] GAP_LOAD      = GCW'(GAP_CYCLES);
    localparam logic [GCW-1:0] GAP_ONE       = GCW'(1);

    // ---------------------------------------------------------------- state
    arb_state_e         state_q,     state_d;
    logic [N_REQ-1:0]   grant_q,     grant_d;
    logic [PW-1:0]      ptr_q,       ptr_d;
    logic [BCW-1:0]     byte_cnt_q,  byte_cnt_d;
    logic [GCW-1:0]     gap_cnt_q,   gap_cnt_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;
    logic [15:0]        split_cnt_q, split_cnt_d;
    // Set when a frame was closed by the size limit; the same owner must get
    // the port back next so the rest of its source frame follows directly.
    logic               split_q,     split_d;

    // ---------------------------------------------------------- arbitration
    logic               arb_en;
    logic [N_REQ-1:0]   arb_gnt;
    logic [PW-1:0]      arb_ptr;

    // A pending split continuation bypasses arbitration entirely.
    assign arb_en = (state_q == ST_IDLE) && i_enable && !split_q;

    rr_arbiter #(
        .N       (N_REQ)
    ) u_rr_arbiter (
        .req     (i_req_tvalid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (arb_gnt),
        .ptr_new (arb_ptr)
    );

    // --------------------------------------------------------- pass-through
    logic [7:0] own_tdata;
    logic       own_tvalid;
    logic       own_tlast;
    logic       at_limit;
    logic       beat;

    always_comb begin
        own_tdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q[k]) begin
                own_tdata = i_req_tdata[8*k +: 8];
            end
        end
        own_tvalid = |(i_req_tvalid & grant_q);
        own_tlast  = |(i_req_tlast  & grant_q);
        at_limit   = (byte_cnt_q == LAST_BYTE_IDX);

        o_axi_tx_tdata  = '0;
        o_axi_tx_tvalid = 1'b0;
        o_axi_tx_tlast  = 1'b0;
        o_req_tready    = '0;
        if (state_q == ST_XFER) begin
            o_axi_tx_tdata  = own_tdata;
            o_axi_tx_tvalid = own_tvalid;
            o_axi_tx_tlast  = own_tlast || at_limit;
            o_req_tready    = grant_q & {N_REQ{i_axi_tx_tready}};
        end
        beat = (state_q == ST_XFER) && own_tvalid && i_axi_tx_tready;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        split_cnt_d = split_cnt_q;
        split_d     = split_q;

        unique case (state_q)
            ST_IDLE: begin
                if (split_q) begin
                    // Owner kept its grant through the gap; just resume.
                    state_d = ST_XFER;
                    split_d = 1'b0;
                end else if (|arb_gnt) begin
                    grant_d = arb_gnt;
                    ptr_d   = arb_ptr;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (beat) begin
                    if (o_axi_tx_tlast) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        byte_cnt_d  = '0;
                        // A source tlast on the limit beat is an ordinary end.
                        if (!own_tlast) begin
                            split_cnt_d = split_cnt_q + 16'd1;
                            split_d     = 1'b1;
                        end else begin
                            grant_d     = '0;
                        end
                        if (GAP_CYCLES > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q <= GAP_ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_axi_tx_clk) begin
        if (!i_axi_tx_rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= PW'(N_REQ - 1);   // requester 0 wins first
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            split_cnt_q <= '0;
            split_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            split_cnt_q <= split_cnt_d;
            split_q     <= split_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_split_cnt = split_cnt_q;

endmodule

// File: tb/tb_enet_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_enet_tx_frame_arbiter
//   Requesters are fed from per-requester byte queues. A reference model keeps
//   a copy of every queued byte and, from the frame rules alone (frames end at
//   source tlast or after MAX_FRAME bytes, a split owner continues, otherwise
//   the next pending requester after the last owner goes next), predicts the
//   owner, data and tlast of every beat on the controller side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_enet_tx_frame_arbiter;

    localparam int N   = 2;
    localparam int MAX = 1024;
    localparam int GAP = 12;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } beat_t;

    typedef struct {
        int     own;
        int     len;
        longint t;
    } frame_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_enable;
    logic [8*N-1:0]  i_req_tdata;
    logic [N-1:0]    i_req_tvalid;
    logic [N-1:0]    i_req_tlast;
    logic [N-1:0]    o_req_tready;
    logic [7:0]      o_axi_tx_tdata;
    logic            o_axi_tx_tvalid;
    logic            o_axi_tx_tlast;
    logic            i_axi_tx_tready;
    logic [N-1:0]    o_grant;
    logic [31:0]     o_frame_cnt;
    logic [15:0]     o_split_cnt;

    enet_tx_frame_arbiter #(
        .N_REQ      (N),
        .MAX_FRAME  (MAX),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_axi_tx_clk    (clk),
        .i_axi_tx_rst_n  (rst_n),
        .i_enable        (i_enable),
        .i_req_tdata     (i_req_tdata),
        .i_req_tvalid    (i_req_tvalid),
        .i_req_tlast     (i_req_tlast),
        .o_req_tready    (o_req_tready),
        .o_axi_tx_tdata  (o_axi_tx_tdata),
        .o_axi_tx_tvalid (o_axi_tx_tvalid),
        .o_axi_tx_tlast  (o_axi_tx_tlast),
        .i_axi_tx_tready (i_axi_tx_tready),
        .o_grant         (o_grant),
        .o_frame_cnt     (o_frame_cnt),
        .o_split_cnt     (o_split_cnt)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ sources / model
    beat_t  src_q[N][$];
    beat_t  ref_q[N][$];
    frame_t frame_log[$];
    logic [N-1:0] acc;
    bit     tready_rand = 1'b0;
    bit     bubbles     = 1'b0;

    bit     in_frame;
    int     cur_owner;
    int     flen;
    int     last_owner;
    bit     last_split;
    int     m_frames;
    int     m_splits;
    int     gap_left;
    bit     quiet_ok;
    longint cyc = 0;

    task automatic load_frame(input int k, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d    = 8'($urandom);
            b.last = (i == len - 1);
            src_q[k].push_back(b);
            ref_q[k].push_back(b);
        end
    endtask

    function automatic int next_pending(input int o);
        for (int i = 1; i <= N; i++) begin
            if (ref_q[(o + i) % N].size() != 0) return (o + i) % N;
        end
        return -1;
    endfunction

    // Driver: just after each rising edge, retire accepted bytes and present
    // the next ones.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
                if (src_q[k].size() != 0) begin
                    i_req_tvalid[k]       = (o_grant[k] && bubbles) ? ($urandom_range(3) != 0) : 1'b1;
                    i_req_tdata[8*k +: 8] = src_q[k][0].d;
                    i_req_tlast[k]        = src_q[k][0].last;
                end else begin
                    i_req_tvalid[k]       = 1'b0;
                    i_req_tdata[8*k +: 8] = 8'h00;
                    i_req_tlast[k]        = 1'b0;
                end
            end
            i_axi_tx_tready = tready_rand ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Monitor / scoreboard on the falling edge.
    always @(negedge clk) begin
        int     own;
        int     exp_own;
        beat_t  eb;
        bit     exp_last;
        frame_t fr;
        logic [N-1:0] gap_grant;
        cyc++;
        acc = i_req_tvalid & o_req_tready & {N{rst_n}};
        if (!rst_n) begin
            in_frame   = 1'b0;
            flen       = 0;
            last_owner = N - 1;
            last_split = 1'b0;
            m_frames   = 0;
            m_splits   = 0;
            gap_left   = 0;
        end else begin
            check("tready_non_owner", 32'(o_req_tready & ~o_grant), 32'd0);
            if (gap_left > 0) begin
                gap_grant = last_split ? N'(1 << last_owner) : '0;
                if (o_axi_tx_tvalid || o_req_tready != '0 || o_grant != gap_grant) quiet_ok = 1'b0;
                gap_left--;
                if (gap_left == 0) check("gap_quiet", 32'(quiet_ok), 32'd1);
            end
            if (o_axi_tx_tvalid && i_axi_tx_tready) begin
                own = 0;
                for (int k = 0; k < N; k++) if (o_grant[k]) own = k;
                check("grant_onehot", 32'($onehot(o_grant)), 32'd1);
                if (!in_frame) begin
                    exp_own = last_split ? last_owner : next_pending(last_owner);
                    check("owner", 32'(own), 32'(exp_own));
                    in_frame  = 1'b1;
                    cur_owner = own;
                    flen      = 0;
                end else begin
                    check("owner_hold", 32'(own), 32'(cur_owner));
                end
                if (ref_q[own].size() == 0) begin
                    check("underflow", 32'(own), 32'hFFFF_FFFF);
                end else begin
                    eb       = ref_q[own].pop_front();
                    exp_last = eb.last || (flen + 1 == MAX);
                    check("tdata", 32'(o_axi_tx_tdata), 32'(eb.d));
                    check("tlast", 32'(o_axi_tx_tlast), 32'(exp_last));
                    flen++;
                    if (exp_last) begin
                        m_frames++;
                        if (!eb.last) m_splits++;
                        last_split = !eb.last;
                        last_owner = own;
                        in_frame   = 1'b0;
                        fr.own = own; fr.len = flen; fr.t = cyc;
                        frame_log.push_back(fr);
                        gap_left = GAP + 1;
                        quiet_ok = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic clear_queues();
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            ref_q[k].delete();
        end
        frame_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_cyc(2);
        clear_queues();
        rst_n = 1'b1;
        wait_cyc(1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(ref_q[0].size() == 0 && ref_q[1].size() == 0 && !in_frame && gap_left == 0)) begin
            wait_cyc(1);
            n++;
            if (n >= budget) begin
                check("drain_timeout", 32'(n), 32'(budget - 1));
                return;
            end
        end
        wait_cyc(GAP + 3);
    endtask

    task automatic check_frame(input string tag, input int i, input int own, input int len);
        if (i >= frame_log.size()) begin
            check(tag, 32'(frame_log.size()), 32'(i + 1));
        end else begin
            check({tag, "_own"}, 32'(frame_log[i].own), 32'(own));
            check({tag, "_len"}, 32'(frame_log[i].len), 32'(len));
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int   cnt;
        logic [7:0] first_byte;
        rst_n           = 1'b0;
        i_enable        = 1'b1;
        i_req_tdata     = '0;
        i_req_tvalid    = '0;
        i_req_tlast     = '0;
        i_axi_tx_tready = 1'b1;

        // 1. reset with every requester valid, then release
        wait_cyc(2);
        clear_queues();
        load_frame(0, 4);
        load_frame(1, 4);
        first_byte = ref_q[0][0].d;
        wait_cyc(3);
        check("rst_grant",  32'(o_grant),         32'd0);
        check("rst_tready", 32'(o_req_tready),    32'd0);
        check("rst_tvalid", 32'(o_axi_tx_tvalid), 32'd0);
        check("rst_tlast",  32'(o_axi_tx_tlast),  32'd0);
        check("rst_tdata",  32'(o_axi_tx_tdata),  32'd0);
        check("rst_frames", o_frame_cnt,          32'd0);
        check("rst_splits", 32'(o_split_cnt),     32'd0);
        rst_n = 1'b1;
        check("rel_grant0", 32'(o_grant), 32'd0);
        wait_cyc(1);
        check("rel_grant1", 32'(o_grant),         32'b01);
        check("rel_tvalid", 32'(o_axi_tx_tvalid), 32'd1);
        check("rel_tdata",  32'(o_axi_tx_tdata),  32'(first_byte));
        wait_idle(2000);
        check("t1_frames", o_frame_cnt, 32'd2);

        // 2. alternating 4-byte frames, full-rate tready
        do_reset();
        load_frame(0, 4);
        load_frame(0, 4);
        load_frame(1, 4);
        wait_idle(2000);
        check_frame("t2_f0", 0, 0, 4);
        check_frame("t2_f1", 1, 1, 4);
        check_frame("t2_f2", 2, 0, 4);
        if (frame_log.size() == 3) begin
            check("t2_spacing0", 32'(frame_log[1].t - frame_log[0].t), 32'(GAP + 1 + 4));
            check("t2_spacing1", 32'(frame_log[2].t - frame_log[1].t), 32'(GAP + 1 + 4));
        end
        check("t2_frames", o_frame_cnt,      32'd3);
        check("t2_splits", 32'(o_split_cnt), 32'd0);

        // 3. 2500-byte frame split twice; req1 waits throughout
        do_reset();
        load_frame(0, 2500);
        load_frame(1, 4);
        wait_idle(8000);
        check_frame("t3_f0", 0, 0, 1024);
        check_frame("t3_f1", 1, 0, 1024);
        check_frame("t3_f2", 2, 0, 452);
        check_frame("t3_f3", 3, 1, 4);
        check("t3_splits", 32'(o_split_cnt), 32'd2);
        check("t3_frames", o_frame_cnt,      32'd4);

        // 4. source tlast exactly on the limit byte
        do_reset();
        load_frame(0, MAX);
        load_frame(1, 4);
        wait_idle(4000);
        check_frame("t4_f0", 0, 0, MAX);
        check_frame("t4_f1", 1, 1, 4);
        check("t4_splits", 32'(o_split_cnt), 32'd0);
        check("t4_frames", o_frame_cnt,      32'd2);

        // 5. random tready and source bubbles on 300-byte frames
        do_reset();
        tready_rand = 1'b1;
        bubbles     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_frame(0, 300);
            load_frame(1, 300);
        end
        wait_idle(20000);
        tready_rand = 1'b0;
        bubbles     = 1'b0;
        check("t5_nframes", 32'(frame_log.size()), 32'd6);
        check("t5_frames",  o_frame_cnt,           32'd6);
        check("t5_splits",  32'(o_split_cnt),      32'd0);

        // 6a. enable dropped mid-frame
        do_reset();
        load_frame(0, 20);
        load_frame(1, 4);
        cnt = 0;
        while (ref_q[0].size() > 17 && cnt < 200) begin wait_cyc(1); cnt++; end
        check("t6_started", 32'(cnt < 200), 32'd1);
        i_enable = 1'b0;
        cnt = 0;
        while ((ref_q[0].size() != 0 || in_frame) && cnt < 500) begin wait_cyc(1); cnt++; end
        check("t6_completed", 32'(cnt < 500), 32'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_grant != '0) cnt++;
            wait_cyc(1);
        end
        check("t6_no_grant", 32'(cnt), 32'd0);
        check("t6_req1_held", 32'(ref_q[1].size()), 32'd4);
        i_enable = 1'b1;
        wait_idle(2000);
        check("t6_frames", o_frame_cnt, 32'd2);

        // 6b. reset mid-frame, then a frame proving the byte count restarted
        load_frame(0, 50);
        cnt = 0;
        while (ref_q[0].size() > 40 && cnt < 500) begin wait_cyc(1); cnt++; end
        check("t6_mid", 32'(cnt < 500), 32'd1);
        rst_n = 1'b0;
        wait_cyc(1);
        check("t6_rst_grant",  32'(o_grant),         32'd0);
        check("t6_rst_tvalid", 32'(o_axi_tx_tvalid), 32'd0);
        check("t6_rst_tlast",  32'(o_axi_tx_tlast),  32'd0);
        check("t6_rst_frames", o_frame_cnt,          32'd0);
        clear_queues();
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(1);
        load_frame(0, MAX + 6);
        wait_idle(4000);
        check_frame("t6_f0", 0, 0, MAX);
        check_frame("t6_f1", 1, 0, 6);
        check("t6_splits", 32'(o_split_cnt), 32'd1);
        check("t6_frames2", o_frame_cnt,     32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
